// File: rtl/dot_accumulator.sv
// Burst dot-product accumulator: sums 1..(2^CNT_W-1) unsigned products from the
// upstream multiplier and returns one result per burst over a valid/ready port.
module dot_accumulator #(
   parameter int PROD_W = 8,
   parameter int CNT_W  = 4,
   parameter int ACC_W  = 12
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              start_i,
   input  logic [CNT_W-1:0]  len_i,
   output logic              busy_o,
   input  logic [PROD_W-1:0] prod_i,
   input  logic              in_valid_i,
   output logic              in_ready_o,
   output logic [ACC_W-1:0]  result_o,
   output logic              out_valid_o,
   input  logic              out_ready_i,
   output logic [CNT_W-1:0]  remaining_o
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACC  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t             state_q;
   logic [ACC_W-1:0]   acc_q;
   logic [ACC_W-1:0]   result_q;
   logic [CNT_W-1:0]   remaining_q;
   logic               in_ready_q;
   logic               out_valid_q;
   logic               busy_q;

   logic [ACC_W-1:0]   sum_d;
   logic               beat;

   // ACC_W >= PROD_W + CNT_W, so the zero-extended sum can never wrap.
   assign sum_d = acc_q + ACC_W'(prod_i);
   assign beat  = in_valid_i && in_ready_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= IDLE;
         acc_q       <= '0;
         result_q    <= '0;
         remaining_q <= '0;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start_i) begin
                  busy_q <= 1'b1;
                  if (len_i != '0) begin
                     remaining_q <= len_i;
                     acc_q       <= '0;
                     in_ready_q  <= 1'b1;
                     state_q     <= ACC;
                  end else begin
                     result_q    <= '0;
                     out_valid_q <= 1'b1;
                     state_q     <= DONE;
                  end
               end
            end
            ACC: begin
               if (beat) begin
                  acc_q       <= sum_d;
                  remaining_q <= remaining_q - 1'b1;
                  if (remaining_q == CNT_W'(1)) begin
                     result_q    <= sum_d;
                     in_ready_q  <= 1'b0;
                     out_valid_q <= 1'b1;
                     state_q     <= DONE;
                  end
               end
            end
            DONE: begin
               // start in the handshake cycle is deliberately dropped
               if (out_ready_i) begin
                  out_valid_q <= 1'b0;
                  busy_q      <= 1'b0;
                  state_q     <= IDLE;
               end
            end
            default: begin
               state_q     <= IDLE;
               in_ready_q  <= 1'b0;
               out_valid_q <= 1'b0;
               busy_q      <= 1'b0;
            end
         endcase
      end
   end

   assign busy_o      = busy_q;
   assign in_ready_o  = in_ready_q;
   assign out_valid_o = out_valid_q;
   assign result_o    = result_q;
   assign remaining_o = remaining_q;

endmodule

// File: tb/tb_dot_accumulator.sv
// Directed bench for dot_accumulator with hand-computed burst sums.
module tb_dot_accumulator;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [3:0]  len;
   logic        busy;
   logic [7:0]  prod;
   logic        in_valid;
   logic        in_ready;
   logic [11:0] result;
   logic        out_valid;
   logic        out_ready;
   logic [3:0]  remaining;

   int checks   = 0;
   int failures = 0;

   dot_accumulator #(.PROD_W(8), .CNT_W(4), .ACC_W(12)) dut (
      .clk_i(clk), .rst_i(rst), .start_i(start), .len_i(len), .busy_o(busy),
      .prod_i(prod), .in_valid_i(in_valid), .in_ready_o(in_ready),
      .result_o(result), .out_valid_o(out_valid), .out_ready_i(out_ready),
      .remaining_o(remaining)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_busy"},   16'(busy), 16'd0);
      chk({tag, "_inrdy"},  16'(in_ready), 16'd0);
      chk({tag, "_ovld"},   16'(out_valid), 16'd0);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; len = '0; prod = '0; in_valid = 1'b0; out_ready = 1'b0;
      #2;
      chk_idle("rst0");
      chk("rst0_result", 16'(result), 16'd0);
      chk("rst0_rem",    16'(remaining), 16'd0);
      tick();
      rst = 1'b0;
      tick();

      // reset in the middle of an accumulation
      start = 1'b1; len = 4'd5;
      tick();
      start = 1'b0; in_valid = 1'b1; prod = 8'd10;
      tick(); tick();
      in_valid = 1'b0;
      chk("mid_rem", 16'(remaining), 16'd3);
      chk("mid_inrdy", 16'(in_ready), 16'd1);
      rst = 1'b1;
      #1;
      chk_idle("rstacc");
      chk("rstacc_result", 16'(result), 16'd0);
      chk("rstacc_rem",    16'(remaining), 16'd0);
      #2 rst = 1'b0;
      tick();
      start = 1'b1; len = 4'd1;
      tick();
      start = 1'b0;
      chk("l1_inrdy", 16'(in_ready), 16'd1);
      in_valid = 1'b1; prod = 8'd7;
      tick();
      in_valid = 1'b0;
      chk("l1_ovld",   16'(out_valid), 16'd1);
      chk("l1_result", 16'(result), 16'd7);
      out_ready = 1'b1;
      tick();
      chk_idle("l1_after");
      out_ready = 1'b0;

      // nominal burst 6+12+20+225 = 263, out_ready held high
      out_ready = 1'b1;
      start = 1'b1; len = 4'd4;
      tick();
      start = 1'b0; in_valid = 1'b1;
      chk("nom_busy", 16'(busy), 16'd1);
      prod = 8'd6;   tick();
      prod = 8'd12;  tick();
      prod = 8'd20;  tick();
      chk("nom_ovld_early", 16'(out_valid), 16'd0);
      prod = 8'd225; tick();
      in_valid = 1'b0;
      chk("nom_ovld",   16'(out_valid), 16'd1);
      chk("nom_result", 16'(result), 16'd263);
      chk("nom_inrdy",  16'(in_ready), 16'd0);
      tick();
      chk_idle("nom_after");
      out_ready = 1'b0;

      // 15 x 225 = 3375
      start = 1'b1; len = 4'd15;
      tick();
      start = 1'b0; in_valid = 1'b1; prod = 8'd225;
      for (int i = 0; i < 15; i++) tick();
      in_valid = 1'b0;
      chk("max_ovld",   16'(out_valid), 16'd1);
      chk("max_result", 16'(result), 16'hD2F);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk_idle("max_after");

      // bubbles then backpressure
      start = 1'b1; len = 4'd3;
      tick();
      start = 1'b0;
      in_valid = 1'b1; prod = 8'd1; tick();
      in_valid = 1'b0; prod = 8'd99; tick();
      chk("bub_rem", 16'(remaining), 16'd2);
      tick();
      in_valid = 1'b1; prod = 8'd2; tick();
      in_valid = 1'b0; prod = 8'd50; tick();
      chk("bub_rem2", 16'(remaining), 16'd1);
      in_valid = 1'b1; prod = 8'd3; tick();
      in_valid = 1'b0;
      chk("bub_ovld",   16'(out_valid), 16'd1);
      chk("bub_result", 16'(result), 16'd6);
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1; prod = 8'd77;
         tick();
         chk("stall_ovld",   16'(out_valid), 16'd1);
         chk("stall_result", 16'(result), 16'd6);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk_idle("bub_after");

      // zero length
      start = 1'b1; len = 4'd0;
      tick();
      start = 1'b0;
      chk("zero_ovld",   16'(out_valid), 16'd1);
      chk("zero_result", 16'(result), 16'd0);
      chk("zero_inrdy",  16'(in_ready), 16'd0);
      chk("zero_busy",   16'(busy), 16'd1);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk_idle("zero_after");

      // start ignored during ACC and in the DONE handshake cycle
      start = 1'b1; len = 4'd2;
      tick();
      len = 4'd9;
      tick();
      chk("ign_rem_hold", 16'(remaining), 16'd2);
      in_valid = 1'b1; prod = 8'd3;
      tick();
      chk("ign_rem1", 16'(remaining), 16'd1);
      prod = 8'd4;
      tick();
      in_valid = 1'b0;
      chk("ign_ovld",   16'(out_valid), 16'd1);
      chk("ign_result", 16'(result), 16'd7);
      chk("ign_rem0",   16'(remaining), 16'd0);
      out_ready = 1'b1;
      tick();
      start = 1'b0; out_ready = 1'b0;
      chk_idle("ign_hs");
      chk("ign_hs_rem", 16'(remaining), 16'd0);
      tick();
      chk_idle("ign_after");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
